// File: rtl/cbus_rr_arbiter.sv
// CBus arbiter: grants one requester the shared cache bus and holds the grant for the whole burst.
// Define CBUS_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (requester 0 highest).

package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;     // burst length minus one
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  cbus_req_t  [NUM_INPUTS-1:0]      ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]      iresps,
  output cbus_req_t                        oreq,
  input  cbus_resp_t                       oresp,
  output logic                             busy,
  output logic       [IDX_W-1:0]           grant_idx
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic             any_valid;
  logic [IDX_W-1:0] winner;

`ifdef CBUS_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] scan_idx;

  // Scan from the farthest candidate back toward ptr+1 so the nearest valid one is written last and wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    any_valid = 1'b0;
    winner    = '0;
    scan_idx  = '0;
    for (int k = NUM_INPUTS; k >= 1; k--) begin
      scan_idx = IDX_W'((int'(ptr_q) + k) % NUM_INPUTS);
      if (ireqs[scan_idx].valid) begin
        any_valid = 1'b1;
        winner    = scan_idx;
      end
    end
  end
`else
  // Lowest valid index wins; scanning downward leaves the lowest one as the final assignment.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (ireqs[i].valid) begin
        any_valid = 1'b1;
        winner    = IDX_W'(i);
      end
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
`ifdef CBUS_ARB_RR_EN
      ptr_q       <= IDX_W'(NUM_INPUTS - 1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            grant_idx_q <= winner;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (oresp.ready && oresp.last) begin
            state_q <= IDLE;
`ifdef CBUS_ARB_RR_EN
            ptr_q   <= grant_idx_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // While granted, the grantee is wired straight through; reset forces both sides quiet in the same cycle.
  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (!reset && state_q == BUSY) begin
      oreq                = ireqs[grant_idx_q];
      iresps[grant_idx_q] = oresp;
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant_idx = grant_idx_q;

  grant_in_range_a: assert property (@(posedge clk) disable iff (reset)
    busy |-> (int'(grant_idx_q) < NUM_INPUTS));

endmodule
